// File: rtl/trace_flush_arbiter_if.sv
// Requester-side and engine-side bundles for the trace flush arbiter.
// The arbiter is the slave of the requester bundle and the master of the engine bundle.
interface tfa_req_if #(
   parameter int NumReq          = 4,
   parameter int BufferAddrWidth = 10
);
   logic [NumReq-1:0]                 req_valid;
   logic [NumReq-1:0]                 req_ready;
   logic [NumReq*BufferAddrWidth-1:0] req_ptr;
   logic [NumReq*BufferAddrWidth-1:0] req_size;
   logic [NumReq-1:0]                 cmpl_valid;
   logic                              cmpl_err;
   logic [NumReq-1:0]                 wrapped;
   logic [NumReq-1:0]                 wrapped_clr;
   logic                              busy;

   modport master (
      output req_valid, req_ptr, req_size, wrapped_clr,
      input  req_ready, cmpl_valid, cmpl_err, wrapped, busy
   );
   modport slave (
      input  req_valid, req_ptr, req_size, wrapped_clr,
      output req_ready, cmpl_valid, cmpl_err, wrapped, busy
   );
endinterface

interface tfa_eng_if #(
   parameter int BufferAddrWidth = 10,
   parameter int AXIAddrWidth    = 64
);
   logic                       eng_start_valid;
   logic                       eng_start_ready;
   logic [BufferAddrWidth-1:0] eng_data_ptr;
   logic [BufferAddrWidth-1:0] eng_data_size;
   logic [AXIAddrWidth-1:0]    eng_axi_offset;
   logic                       eng_done_valid;
   logic                       eng_done_ready;

   modport master (
      output eng_start_valid, eng_data_ptr, eng_data_size, eng_axi_offset, eng_done_ready,
      input  eng_start_ready, eng_done_valid
   );
   modport slave (
      input  eng_start_valid, eng_data_ptr, eng_data_size, eng_axi_offset, eng_done_ready,
      output eng_start_ready, eng_done_valid
   );
endinterface

// File: rtl/trace_flush_arbiter.sv
// Round-robin flush scheduler: one burst engine shared by NumReq trace buffers, each with a host ring region.
// Accept->start 1 cycle, done->completion 1 cycle; no new grant until the current flush completes.
module trace_flush_arbiter #(
   parameter int                      NumReq          = 4,
   parameter int                      BufferAddrWidth = 10,
   parameter int                      AXIAddrWidth    = 64,
   parameter int                      AXIDataWidth    = 32,
   parameter logic [AXIAddrWidth-1:0] BaseAddr        = '0,
   parameter int                      RegionWords     = 4096
) (
   input  logic      clk,
   input  logic      reset,
   tfa_req_if.slave  req_if,
   tfa_eng_if.master eng_if
);
   localparam int Bpw  = AXIDataWidth / 8;
   localparam int IdW  = $clog2(NumReq);
   localparam int PtrW = $clog2(RegionWords) + 1;
   localparam int Baw  = BufferAddrWidth;
   localparam int CmpW = ((Baw > PtrW) ? Baw : PtrW) + 1;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CMPL} state_e;

   state_e                  state_q;
   logic [IdW-1:0]          id_q;
   logic [IdW-1:0]          last_grant_q;
   logic [PtrW-1:0]         start_q;
   logic [Baw-1:0]          ptr_q;
   logic [Baw-1:0]          size_q;
   logic                    err_q;
   logic [AXIAddrWidth-1:0] offset_q;
   logic [PtrW-1:0]         wr_ptr_q [NumReq];
   logic [NumReq-1:0]       wrapped_q;
   logic [NumReq-1:0]       cmpl_valid_q;
   logic                    cmpl_err_q;
   logic                    start_valid_q;
   logic                    done_ready_q;
   logic                    busy_q;

   logic                    gnt_vld;
   logic [IdW-1:0]          gnt_id;
   logic [IdW-1:0]          cand;
   logic [NumReq-1:0]       gnt_oh;
   logic                    accept;
   logic [Baw-1:0]          sel_ptr;
   logic [Baw-1:0]          sel_size;
   logic [PtrW-1:0]         sel_wp;
   logic [PtrW-1:0]         start_d;
   logic                    err_d;
   logic                    wrap_d;
   logic [AXIAddrWidth-1:0] offset_d;
   logic [NumReq-1:0]       wrapped_set;

   // Search begins one past the last completed grant so every requester gets a turn.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_id  = '0;
      cand    = '0;
      for (int k = 1; k <= NumReq; k++) begin
         cand = IdW'((int'(last_grant_q) + k) % NumReq);
         if (!gnt_vld && req_if.req_valid[cand]) begin
            gnt_vld = 1'b1;
            gnt_id  = cand;
         end
      end
      gnt_oh = NumReq'(1) << gnt_id;
      accept = (state_q == IDLE) && gnt_vld;
   end

   always_comb begin
      sel_ptr  = req_if.req_ptr[int'(gnt_id)*Baw +: Baw];
      sel_size = req_if.req_size[int'(gnt_id)*Baw +: Baw];
      sel_wp   = wr_ptr_q[gnt_id];
      err_d    = (sel_size == '0) || (CmpW'(sel_size) > CmpW'(RegionWords));
      // A flush that would cross the region end restarts at the region base instead of splitting.
      wrap_d   = !err_d && ((CmpW'(sel_wp) + CmpW'(sel_size)) > CmpW'(RegionWords));
      start_d  = wrap_d ? '0 : sel_wp;
      offset_d = BaseAddr + (AXIAddrWidth'(gnt_id) * AXIAddrWidth'(RegionWords)
                             + AXIAddrWidth'(start_d)) * AXIAddrWidth'(Bpw);
      wrapped_set = (accept && wrap_d) ? gnt_oh : '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         id_q          <= '0;
         last_grant_q  <= IdW'(NumReq - 1);
         start_q       <= '0;
         ptr_q         <= '0;
         size_q        <= '0;
         err_q         <= 1'b0;
         offset_q      <= '0;
         wrapped_q     <= '0;
         cmpl_valid_q  <= '0;
         cmpl_err_q    <= 1'b0;
         start_valid_q <= 1'b0;
         done_ready_q  <= 1'b0;
         busy_q        <= 1'b0;
         for (int i = 0; i < NumReq; i++) begin
            wr_ptr_q[i] <= '0;
         end
      end else begin
         // Set has priority over a same-cycle clear.
         wrapped_q    <= (wrapped_q & ~req_if.wrapped_clr) | wrapped_set;
         cmpl_valid_q <= '0;
         cmpl_err_q   <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (accept) begin
                  id_q     <= gnt_id;
                  ptr_q    <= sel_ptr;
                  size_q   <= sel_size;
                  start_q  <= start_d;
                  err_q    <= err_d;
                  offset_q <= offset_d;
                  busy_q   <= 1'b1;
                  if (err_d) begin
                     state_q      <= CMPL;
                     cmpl_valid_q <= gnt_oh;
                     cmpl_err_q   <= 1'b1;
                  end else begin
                     state_q       <= ISSUE;
                     start_valid_q <= 1'b1;
                  end
               end
            end
            ISSUE: begin
               if (start_valid_q && eng_if.eng_start_ready) begin
                  start_valid_q <= 1'b0;
                  done_ready_q  <= 1'b1;
                  state_q       <= WAIT;
               end
            end
            WAIT: begin
               if (done_ready_q && eng_if.eng_done_valid) begin
                  done_ready_q <= 1'b0;
                  cmpl_valid_q <= NumReq'(1) << id_q;
                  cmpl_err_q   <= err_q;
                  state_q      <= CMPL;
               end
            end
            CMPL: begin
               if (!err_q) begin
                  wr_ptr_q[id_q] <= start_q + PtrW'(size_q);
               end
               last_grant_q <= id_q;
               busy_q       <= 1'b0;
               state_q      <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign req_if.req_ready      = accept ? gnt_oh : '0;
   assign req_if.cmpl_valid     = cmpl_valid_q;
   assign req_if.cmpl_err       = cmpl_err_q;
   assign req_if.wrapped        = wrapped_q;
   assign req_if.busy           = busy_q;
   assign eng_if.eng_start_valid = start_valid_q;
   assign eng_if.eng_data_ptr    = ptr_q;
   assign eng_if.eng_data_size   = size_q;
   assign eng_if.eng_axi_offset  = offset_q;
   assign eng_if.eng_done_ready  = done_ready_q;

endmodule

// File: tb/tb_trace_flush_arbiter.sv
// Directed bench for trace_flush_arbiter: vector table of single flushes plus contention and reset-in-WAIT sequences.
module tb_trace_flush_arbiter;
   localparam int NR  = 4;
   localparam int BAW = 13;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   tfa_req_if #(.NumReq(NR), .BufferAddrWidth(BAW)) rif ();
   tfa_eng_if #(.BufferAddrWidth(BAW), .AXIAddrWidth(64)) eif ();

   trace_flush_arbiter #(
      .NumReq(NR), .BufferAddrWidth(BAW), .AXIAddrWidth(64), .AXIDataWidth(32),
      .BaseAddr(64'h0), .RegionWords(4096)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .req_if (rif.slave),
      .eng_if (eif.master)
   );

   typedef struct {
      logic [1:0]     id;
      logic [BAW-1:0] ptr;
      logic [BAW-1:0] size;
      int             srd;
      int             dd;
      logic [3:0]     clr;
      logic           err;
      logic [63:0]    off;
      logic [3:0]     wrp;
   } vec_t;

   vec_t        vt [11];
   logic [1:0]  ord [5];
   logic [63:0] offs [5];
   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_req_ready"},  64'(rif.req_ready),       64'h0);
      chk({tag, "_cmpl_valid"}, 64'(rif.cmpl_valid),      64'h0);
      chk({tag, "_cmpl_err"},   64'(rif.cmpl_err),        64'h0);
      chk({tag, "_wrapped"},    64'(rif.wrapped),         64'h0);
      chk({tag, "_busy"},       64'(rif.busy),            64'h0);
      chk({tag, "_start_vld"},  64'(eif.eng_start_valid), 64'h0);
      chk({tag, "_done_rdy"},   64'(eif.eng_done_ready),  64'h0);
      chk({tag, "_ptr"},        64'(eif.eng_data_ptr),    64'h0);
      chk({tag, "_size"},       64'(eif.eng_data_size),   64'h0);
      chk({tag, "_offset"},     eif.eng_axi_offset,       64'h0);
   endtask

   // Entered and left at a falling edge with the arbiter idle.
   task automatic flush(input logic [1:0] id, input logic [BAW-1:0] ptr, input logic [BAW-1:0] size,
                        input int srd, input int dd, input logic [3:0] clr,
                        input logic exp_err, input logic [63:0] exp_off);
      logic [3:0] oh;
      oh = 4'b0001 << id;
      rif.req_valid[id] = 1'b1;
      rif.req_ptr[int'(id)*BAW +: BAW]  = ptr;
      rif.req_size[int'(id)*BAW +: BAW] = size;
      rif.wrapped_clr = clr;
      #1;
      chk("grant", 64'(rif.req_ready), 64'(oh));
      @(posedge clk);
      @(negedge clk);
      rif.req_valid[id] = 1'b0;
      rif.wrapped_clr   = 4'h0;
      if (exp_err) begin
         chk("rej_cmpl",    64'(rif.cmpl_valid),      64'(oh));
         chk("rej_err",     64'(rif.cmpl_err),        64'h1);
         chk("rej_nostart", 64'(eif.eng_start_valid), 64'h0);
      end else begin
         chk("start_vld", 64'(eif.eng_start_valid), 64'h1);
         chk("offset",    eif.eng_axi_offset,       exp_off);
         chk("eng_ptr",   64'(eif.eng_data_ptr),    64'(ptr));
         chk("eng_size",  64'(eif.eng_data_size),   64'(size));
         for (int i = 0; i < srd; i++) begin
            eif.eng_done_valid = 1'b1;
            @(negedge clk);
            chk("bp_start_vld", 64'(eif.eng_start_valid), 64'h1);
            chk("bp_offset",    eif.eng_axi_offset,       exp_off);
            chk("bp_size",      64'(eif.eng_data_size),   64'(size));
            chk("bp_ready",     64'(rif.req_ready),       64'h0);
         end
         eif.eng_done_valid  = 1'b0;
         eif.eng_start_ready = 1'b1;
         @(posedge clk);
         @(negedge clk);
         eif.eng_start_ready = 1'b0;
         chk("wait_done_rdy",  64'(eif.eng_done_ready),  64'h1);
         chk("wait_start_low", 64'(eif.eng_start_valid), 64'h0);
         for (int i = 0; i < dd; i++) begin
            @(negedge clk);
            chk("wait_hold",  64'(eif.eng_done_ready), 64'h1);
            chk("wait_off",   eif.eng_axi_offset,      exp_off);
            chk("wait_ready", 64'(rif.req_ready),      64'h0);
            chk("wait_busy",  64'(rif.busy),           64'h1);
         end
         eif.eng_done_valid = 1'b1;
         @(posedge clk);
         @(negedge clk);
         eif.eng_done_valid = 1'b0;
         chk("cmpl",          64'(rif.cmpl_valid),     64'(oh));
         chk("cmpl_err",      64'(rif.cmpl_err),       64'h0);
         chk("cmpl_done_rdy", 64'(eif.eng_done_ready), 64'h0);
      end
      @(negedge clk);
      chk("cmpl_pulse", 64'(rif.cmpl_valid), 64'h0);
      chk("idle_busy",  64'(rif.busy),       64'h0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rif.req_valid       = 4'h0;
      rif.req_ptr         = '0;
      rif.req_size        = '0;
      rif.wrapped_clr     = 4'h0;
      eif.eng_start_ready = 1'b0;
      eif.eng_done_valid  = 1'b0;
      reset = 1'b1;

      //           id     ptr       size        srd dd   clr    err   offset        wrapped
      vt[0]  = '{2'd0, 13'h010, 13'd100,  0,  0,  4'h0, 1'b0, 64'h0000, 4'h0};
      vt[1]  = '{2'd0, 13'h020, 13'd50,   2,  3,  4'h0, 1'b0, 64'h0190, 4'h0};
      vt[2]  = '{2'd1, 13'h000, 13'd4000, 0,  1,  4'h0, 1'b0, 64'h4000, 4'h0};
      vt[3]  = '{2'd1, 13'h005, 13'd200,  1,  0,  4'h0, 1'b0, 64'h4000, 4'h2};
      vt[4]  = '{2'd1, 13'h006, 13'd0,    0,  0,  4'h0, 1'b1, 64'h0000, 4'h2};
      vt[5]  = '{2'd1, 13'h006, 13'd4097, 0,  0,  4'h0, 1'b1, 64'h0000, 4'h2};
      vt[6]  = '{2'd1, 13'h007, 13'd96,   0,  0,  4'h0, 1'b0, 64'h4320, 4'h2};
      vt[7]  = '{2'd3, 13'h001, 13'd4096, 0,  0,  4'h0, 1'b0, 64'hC000, 4'h2};
      vt[8]  = '{2'd3, 13'h002, 13'd1,    0,  0,  4'h0, 1'b0, 64'hC000, 4'hA};
      vt[9]  = '{2'd2, 13'h003, 13'd8,    5,  50, 4'h0, 1'b0, 64'h8000, 4'hA};
      vt[10] = '{2'd3, 13'h004, 13'd4096, 0,  0,  4'hA, 1'b0, 64'hC000, 4'h8};

      ord[0] = 2'd0; offs[0] = 64'h0258;
      ord[1] = 2'd1; offs[1] = 64'h44A0;
      ord[2] = 2'd2; offs[2] = 64'h8020;
      ord[3] = 2'd3; offs[3] = 64'hC000;
      ord[4] = 2'd0; offs[4] = 64'h0278;

      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      check_reset("rst");

      for (int v = 0; v < 11; v++) begin
         flush(vt[v].id, vt[v].ptr, vt[v].size, vt[v].srd, vt[v].dd, vt[v].clr, vt[v].err, vt[v].off);
         chk($sformatf("v%0d_wrapped", v), 64'(rif.wrapped), 64'(vt[v].wrp));
      end

      // All four requesters contend; each re-raises right after being served.
      rif.req_ptr   = {4{13'h100}};
      rif.req_size  = {4{13'd8}};
      rif.req_valid = 4'hF;
      for (int n = 0; n < 5; n++) begin
         flush(ord[n], 13'h100, 13'd8, 0, 0, 4'h0, 1'b0, offs[n]);
         rif.req_valid[ord[n]] = 1'b1;
      end
      rif.req_valid = 4'h0;
      chk("rr_wrapped", 64'(rif.wrapped), 64'h8);

      // Reset while the engine owns the flush.
      rif.req_valid[1] = 1'b1;
      rif.req_size[BAW +: BAW] = 13'd8;
      @(posedge clk);
      @(negedge clk);
      rif.req_valid[1] = 1'b0;
      eif.eng_start_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      eif.eng_start_ready = 1'b0;
      chk("pre_rst_wait", 64'(eif.eng_done_ready), 64'h1);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      check_reset("rst_wait");
      @(negedge clk);
      chk("rst_no_cmpl", 64'(rif.cmpl_valid), 64'h0);
      flush(2'd1, 13'h040, 13'd8, 0, 0, 4'h0, 1'b0, 64'h4000);
      flush(2'd1, 13'h041, 13'd8, 0, 0, 4'h0, 1'b0, 64'h4020);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/trace_flush_arbiter.md
# trace_flush_arbiter

Round-robin scheduler that shares one AXI burst write engine among `NumReq` on-chip trace buffers. It accepts flush requests (buffer pointer and word count), assigns each requester a private ring region in host memory, and computes the AXI byte offset for each flush. It then drives the engine's start/done handshake and returns a per-requester completion pulse. It sits between the trace capture buffers and the burst write engine inside the tracer.

## Interface
- `NumReq`, 4: number of requesters (2..8).
- `BufferAddrWidth`, 10: width of buffer pointer and size; must match the engine.
- `AXIAddrWidth`, 64: AXI byte-address width.
- `AXIDataWidth`, 32: AXI data width; bytes per word `BPW = AXIDataWidth/8`.
- `BaseAddr`, 0: host byte address of region 0.
- `RegionWords`, 4096: words per requester region; must be a power of two.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  NumReq  per-requester flush request.
- `req_ready`  out  NumReq  one-hot accept.
- `req_ptr`  in  NumReq*BufferAddrWidth  flat buffer start pointers; requester i uses slice i.
- `req_size`  in  NumReq*BufferAddrWidth  flat word counts.
- `cmpl_valid`  out  NumReq  one-cycle completion pulse.
- `cmpl_err`  out  1  qualifies `cmpl_valid`; 1 = request rejected.
- `wrapped`  out  NumReq  sticky flag: region i has wrapped at least once.
- `wrapped_clr`  in  NumReq  clears the matching `wrapped` bit.
- `busy`  out  1  high whenever state != IDLE.
- `eng_start_valid`  out  1  start request to the engine.
- `eng_start_ready`  in  1  engine start ready.
- `eng_data_ptr`  out  BufferAddrWidth  buffer pointer for the engine.
- `eng_data_size`  out  BufferAddrWidth  word count for the engine.
- `eng_axi_offset`  out  AXIAddrWidth  AXI byte offset for the engine.
- `eng_done_valid`  in  1  engine done.
- `eng_done_ready`  out  1  done acknowledge to the engine.

## Operation
- States: IDLE, ISSUE, WAIT, CMPL.
- **IDLE: arbitration.**
  - Search starts at `(last_grant+1) mod NumReq`; the first requester with `req_valid` set wins.
  - The winner gets `req_ready[id]=1` in the same cycle, which forms the handshake.
  - On accept, the block latches `id`, `ptr` and `size`.
- **IDLE: next-state and offset selection after accept.**
  - If `size==0` or `size>RegionWords`, go to CMPL with `err=1`; the engine is not used.
  - Otherwise, if `wr_ptr[id]+size > RegionWords`, then `start=0` and `wrapped[id]` is set. Flushes are never split across the region end.
  - Otherwise `start=wr_ptr[id]`.
  - Go to ISSUE.
- **Offset arithmetic.**
  - `eng_axi_offset = BaseAddr + (id*RegionWords + start)*BPW`.
  - Computed at AXIAddrWidth and registered on accept.
- **ISSUE.**
  - `eng_start_valid=1`.
  - `eng_data_ptr`, `eng_data_size` and `eng_axi_offset` are held stable.
  - On `eng_start_valid & eng_start_ready`, go to WAIT.
- **WAIT.**
  - `eng_done_ready=1`.
  - On `eng_done_valid`, go to CMPL.
- **CMPL.**
  - `cmpl_valid[id]=1` for exactly one cycle; `cmpl_err=err`.
  - If `err==0`: `wr_ptr[id] <= start+size`. The value may equal RegionWords; the next request then wraps.
  - `last_grant <= id`.
  - Go to IDLE.
- **Write-pointer width.** `wr_ptr[i]` is `clog2(RegionWords)+1` bits, one per requester.
- **Simultaneous `wrapped` set and clear** on the same bit in the same cycle: set wins.

## Timing
- **Reset values:**
  - All `req_ready`, `cmpl_valid`, `cmpl_err`, `wrapped`, `eng_start_valid` and `eng_done_ready` are 0.
  - `busy=0`.
  - `eng_data_ptr`, `eng_data_size` and `eng_axi_offset` are 0.
  - All `wr_ptr` are 0; `last_grant = NumReq-1`, so requester 0 has first priority.
- `req_ready` is combinational from `req_valid` and state. At most one bit is set, and only in IDLE.
- **Latency** (request accepted at cycle T):
  - `eng_start_valid` is high at T+1.
  - `cmpl_valid` is high at cycle D+1, where D is the `eng_done_valid` handshake cycle.
  - Minimum request-to-next-accept gap: 4 cycles.
- **Error path:** `cmpl_valid` at T+1; the next accept is possible at T+2.
- Requests that are not granted must hold `req_valid`, `req_ptr` and `req_size` stable until `req_ready`.
- `eng_done_valid` arriving in IDLE or ISSUE is ignored, because `eng_done_ready=0` in those states.
- Reset mid-flush: the block returns to IDLE and clears all ring state. The engine shares the same reset; no completion pulse is emitted.

## Test plan
- **Single flush.** req0, `ptr=0x10`, `size=100`, `BaseAddr=0` -> engine sees `ptr=0x10`, `size=100`, `offset=0`. `cmpl_valid[0]` pulses once with `cmpl_err=0`; `wr_ptr[0]=100`.
- **Round-robin contention.** All 4 requesters hold `req_valid`, each with `size=8` -> grant order 0,1,2,3,0. Requester 2's offset is `2*4096*4 = 0x8000`.
- **Ring wrap.** req1 issues `size=4000` then `size=200` -> second offset is `0x4000` (region start); `wrapped[1]=1` until `wrapped_clr[1]` is pulsed.
- **Rejects.** `size=0` and `size=4097` -> `cmpl_valid` with `cmpl_err=1` at T+1; `eng_start_valid` never rises; `wr_ptr` unchanged.
- **Engine backpressure.** `eng_start_ready` held low for 5 cycles, then done delayed 50 cycles -> outputs stay stable throughout; `req_ready` stays 0 during `busy`.
- **Reset during WAIT.** Assert `reset` while in WAIT -> all outputs return to reset values the next cycle; no `cmpl_valid` is emitted; the next request starts at offset region base.
